// File: rtl/result_arb_pkg.sv
// Shared types and constants for the write-back result bus arbiter.
// Unit indices match the bit positions of the request vectors.
package result_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int BUS_W       = 256;
  localparam int ADDR_W      = 8;
  localparam int ID_W        = 2;
  localparam int UNIT_MULT   = 0;
  localparam int UNIT_ADDSUB = 1;
  localparam int UNIT_TRAN   = 2;

endpackage

// File: rtl/result_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping around.
module rr_pick
  import result_arb_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any_req
);

  int w_best;
  int w_dist;

  // Distance from ptr decides priority; smallest wrapped distance wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    w_best  = N_REQ;
    w_dist  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = (i + N_REQ - int'(ptr)) % N_REQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        winner  = ID_W'(i);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter sharing the single memory write port among the
// matrix functional units; latches one result, writes it, acks the unit.
module result_bus_arbiter
  import result_arb_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int BUS_W   = result_arb_pkg::BUS_W,
  parameter int ADDR_W  = result_arb_pkg::ADDR_W,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic [N_REQ-1:0]        req_fleg,
  input  logic [N_REQ*BUS_W-1:0]  req_data,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    memEN,
  output logic                    memRW,
  output logic [ADDR_W-1:0]       memAddr,
  output logic [BUS_W-1:0]        memWrite,
  input  logic                    memFleg,
  output logic                    busy,
  output logic [1:0]              grant_id,
  output logic                    write_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_grant;
  logic [BUS_W-1:0]   r_data;
  logic [ADDR_W-1:0]  r_addr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mem_en;
  logic               r_busy;
  logic               r_err;
  logic [N_REQ-1:0]   r_ack;

  logic [ID_W-1:0]    w_win;
  logic               w_any;
  logic               w_timeout;
  logic [BUS_W-1:0]   w_sel_data;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [N_REQ-1:0]   w_ack_vec;
  logic [ID_W-1:0]    w_ptr_nxt;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req     (req_fleg),
    .ptr     (r_ptr),
    .winner  (w_win),
    .any_req (w_any)
  );

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_ptr_nxt = (r_grant == ID_W'(N_REQ - 1)) ?
                     '0 : r_grant + ID_W'(1);

  always_comb begin
    w_sel_data = '0;
    w_sel_addr = '0;
    w_ack_vec  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_sel_data = req_data[i*BUS_W +: BUS_W];
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
      w_ack_vec[i] = (r_grant == ID_W'(i));
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = WRITE;
      WRITE:   if (memFleg || w_timeout) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so nothing leaks
  // combinationally from the inputs.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_grant  <= '0;
      r_data   <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_mem_en <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_ack    <= '0;
    end else begin
      r_state  <= w_next;
      r_mem_en <= (w_next == WRITE);
      r_busy   <= (w_next != IDLE);
      r_ack    <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_win;
            r_data  <= w_sel_data;
            r_addr  <= w_sel_addr;
            r_cnt   <= '0;
          end
        end
        WRITE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!memFleg && w_timeout) r_err <= 1'b1;
          if (memFleg || w_timeout) r_ack <= w_ack_vec;
        end
        ACK:     r_ptr <= w_ptr_nxt;
        default: ;
      endcase
    end
  end

  assign req_ack   = r_ack;
  assign memEN     = r_mem_en;
  assign memRW     = r_mem_en;
  assign memAddr   = r_addr;
  assign memWrite  = r_data;
  assign busy      = r_busy;
  assign grant_id  = r_grant;
  assign write_err = r_err;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Scoreboard bench for result_bus_arbiter: stimulus pushes expected
// services, a monitor pops and checks on every ack pulse.
module tb_result_bus_arbiter;

  logic          clk;
  logic          RESET;
  logic [2:0]    req_fleg;
  logic [767:0]  req_data;
  logic [23:0]   req_addr;
  logic [2:0]    req_ack;
  logic          memEN;
  logic          memRW;
  logic [7:0]    memAddr;
  logic [255:0]  memWrite;
  logic          memFleg;
  logic          busy;
  logic [1:0]    grant_id;
  logic          write_err;

  typedef struct {
    int           unit;
    logic [7:0]   addr;
    logic [255:0] data;
    logic         err;
    int           wc;
  } exp_t;

  exp_t         q[$];
  int           n_chk;
  int           n_fail;
  int           delay;
  int           mem_cnt;
  int           wc;
  logic [7:0]   cap_addr;
  logic [255:0] cap_data;
  logic         rw_ok;

  result_bus_arbiter dut (
    .clk       (clk),
    .RESET     (RESET),
    .req_fleg  (req_fleg),
    .req_data  (req_data),
    .req_addr  (req_addr),
    .req_ack   (req_ack),
    .memEN     (memEN),
    .memRW     (memRW),
    .memAddr   (memAddr),
    .memWrite  (memWrite),
    .memFleg   (memFleg),
    .busy      (busy),
    .grant_id  (grant_id),
    .write_err (write_err)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] fill(input logic [15:0] e);
    return {16{e}};
  endfunction

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic load(input int u, input logic [7:0] a,
                      input logic [15:0] e);
    req_data[u*256 +: 256] = fill(e);
    req_addr[u*8 +: 8]     = a;
  endtask

  task automatic expect_svc(input int u, input logic [7:0] a,
                            input logic [15:0] e, input logic err,
                            input int w);
    exp_t x;
    x.unit = u;
    x.addr = a;
    x.data = fill(e);
    x.err  = err;
    x.wc   = w;
    q.push_back(x);
  endtask

  task automatic raise(input int u);
    req_fleg = req_fleg | (3'b001 << u);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while ((q.size() != 0 || busy || req_fleg != 3'b000) && n < bound) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n >= bound) begin
      n_fail++;
      $display("FAIL drain: %0d services pending after %0d cycles, need 0",
               q.size(), n);
    end
  endtask

  task automatic wait_memen(input int bound);
    int n;
    n = 0;
    while (!memEN && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("memen_seen", 256'(memEN), 256'(1));
  endtask

  // Memory model: memFleg rises in WRITE cycle delay+1; never if delay<0.
  initial begin
    memFleg = 1'b0;
    mem_cnt = 0;
    forever begin
      @(negedge clk);
      if (memEN) begin
        mem_cnt++;
        memFleg = (delay >= 0) && (mem_cnt == delay + 1);
      end else begin
        mem_cnt = 0;
        memFleg = 1'b0;
      end
    end
  end

  // Units drop their flag once they see the ack.
  initial begin
    forever begin
      @(negedge clk);
      req_fleg = req_fleg & ~req_ack;
    end
  end

  initial begin
    exp_t e;
    wc    = 0;
    rw_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (RESET) begin
        wc    = 0;
        rw_ok = 1'b1;
      end else begin
        if (memEN) begin
          wc++;
          cap_addr = memAddr;
          cap_data = memWrite;
          if (memRW !== 1'b1) rw_ok = 1'b0;
        end
        if (req_ack != 3'b000) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_ack: got %b required none", req_ack);
          end else begin
            e = q.pop_front();
            chk("ack_vec", 256'(req_ack), 256'(3'b001 << e.unit));
            chk("grant_id", 256'(grant_id), 256'(e.unit));
            chk("mem_addr", 256'(cap_addr), 256'(e.addr));
            chk("mem_data", cap_data, e.data);
            chk("write_err", 256'(write_err), 256'(e.err));
            chk("write_cycles", 256'(wc), 256'(e.wc));
            chk("mem_rw", 256'(rw_ok), 256'(1));
            chk("memen_in_ack", 256'(memEN), 256'(0));
          end
        end
        if (!busy) begin
          wc    = 0;
          rw_ok = 1'b1;
        end
      end
    end
  end

  initial begin
    int n;
    clk      = 1'b0;
    RESET    = 1'b1;
    req_fleg = '0;
    req_data = '0;
    req_addr = '0;
    delay    = 1;
    n_chk    = 0;
    n_fail   = 0;

    repeat (2) @(negedge clk);
    chk("rst_memen", 256'(memEN), 256'(0));
    chk("rst_memrw", 256'(memRW), 256'(0));
    chk("rst_ack", 256'(req_ack), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_err", 256'(write_err), 256'(0));
    chk("rst_grant", 256'(grant_id), 256'(0));
    chk("rst_addr", 256'(memAddr), 256'(0));
    chk("rst_data", memWrite, 256'(0));
    RESET = 1'b0;
    @(negedge clk);

    // Mult only, memFleg one cycle after memEN: ack in cycle 3.
    load(0, 8'h10, 16'h0003);
    expect_svc(0, 8'h10, 16'h0003, 1'b0, 2);
    raise(0);
    n = 0;
    while (req_ack == 3'b000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 256'(n), 256'(3));
    wait_done(50);

    // Reset so ptr=0, then all three held: order 0,1,2, then 0 again.
    @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    delay = 0;
    load(0, 8'h20, 16'h0A01);
    load(1, 8'h21, 16'h0B02);
    load(2, 8'h22, 16'h0C03);
    expect_svc(0, 8'h20, 16'h0A01, 1'b0, 1);
    expect_svc(1, 8'h21, 16'h0B02, 1'b0, 1);
    expect_svc(2, 8'h22, 16'h0C03, 1'b0, 1);
    req_fleg = 3'b111;
    wait_done(60);
    load(0, 8'h23, 16'h0A55);
    expect_svc(0, 8'h23, 16'h0A55, 1'b0, 1);
    raise(0);
    wait_done(30);

    // ptr=1: unit 1 served while 2 pends; unit 1 data changes in WRITE.
    delay = 3;
    load(1, 8'h31, 16'h1111);
    load(2, 8'h32, 16'h2222);
    expect_svc(1, 8'h31, 16'h1111, 1'b0, 4);
    expect_svc(2, 8'h32, 16'h2222, 1'b0, 4);
    req_fleg = 3'b110;
    wait_memen(20);
    @(negedge clk);
    load(1, 8'hEE, 16'hDEAD);
    wait_done(60);

    // ptr=0: timeout on unit 0, then unit 1 served normally.
    delay = -1;
    load(0, 8'h40, 16'h4444);
    expect_svc(0, 8'h40, 16'h4444, 1'b1, 64);
    raise(0);
    wait_done(200);
    delay = 2;
    load(1, 8'h41, 16'h5555);
    expect_svc(1, 8'h41, 16'h5555, 1'b1, 3);
    raise(1);
    wait_done(40);

    // Reset during WRITE of unit 2 with unit 0 also waiting.
    delay = -1;
    load(2, 8'h50, 16'h6666);
    raise(2);
    wait_memen(20);
    chk("pre_rst_grant", 256'(grant_id), 256'(2));
    repeat (3) @(negedge clk);
    load(0, 8'h51, 16'h7777);
    raise(0);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_memen", 256'(memEN), 256'(0));
    chk("async_busy", 256'(busy), 256'(0));
    chk("async_err", 256'(write_err), 256'(0));
    chk("async_grant", 256'(grant_id), 256'(0));
    chk("async_ack", 256'(req_ack), 256'(0));
    expect_svc(0, 8'h51, 16'h7777, 1'b0, 2);
    expect_svc(2, 8'h50, 16'h6666, 1'b0, 2);
    delay = 1;
    @(negedge clk);
    RESET = 1'b0;
    wait_done(60);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/result_bus_arbiter.md
# result_bus_arbiter

Round-robin write-back arbiter that shares the single 256-bit memory write port among the matrix functional units (multiply, add/subtract, transpose). Each unit raises its done flag with a 4×4×16-bit result and a destination address. The arbiter latches one result, drives the memory write handshake, and acknowledges the unit. It sits between the functional units and `Mem`, under the execution engine's control.

## Interface
Parameters:
- `N_REQ`, 3: number of requesting units (index 0 = mult, 1 = add/sub, 2 = transpose).
- `BUS_W`, 256: result and memory data width (16 elements × 16 bits).
- `ADDR_W`, 8: memory address width.
- `TIMEOUT`, 64: maximum cycles spent in WRITE waiting for `memFleg`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `req_fleg` in N_REQ: per-unit result-valid flag; held high until the unit receives its ack.
- `req_data` in N_REQ×BUS_W: packed results; unit i occupies bits [i*BUS_W +: BUS_W].
- `req_addr` in N_REQ×ADDR_W: packed destination addresses.
- `req_ack` out N_REQ: one-cycle pulse to the served unit.
- `memEN` out 1: memory enable.
- `memRW` out 1: 1 = write; the arbiter only ever writes.
- `memAddr` out ADDR_W: write address.
- `memWrite` out BUS_W: write data.
- `memFleg` in 1: memory done flag.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out 2: index of the unit being served; valid while `busy` is high.
- `write_err` out 1: sticky timeout flag; cleared only by `RESET`.

## Operation
States:
- IDLE: all outputs are inactive.
  - If any `req_fleg` bit is high, pick the winner by round robin starting at `ptr`.
  - Latch the winner's `req_data` and `req_addr` into holding registers.
  - Set `grant_id` to the winner and move to WRITE.
- WRITE:
  - Drive `memEN` = 1, `memRW` = 1, and `memAddr`/`memWrite` from the holding registers.
  - The cycle counter increments each cycle.
  - On `memFleg` = 1, move to ACK.
  - When the counter reaches TIMEOUT-1 without `memFleg`, set `write_err` and move to ACK.
- ACK:
  - `memEN` = 0.
  - `req_ack[grant_id]` = 1 for this cycle only.
  - Set `ptr` to (grant_id+1) mod N_REQ.
  - Move to IDLE.

Rules:
- Round robin: the first set bit at or after `ptr`, wrapping around. A single requester is served repeatedly with no starvation penalty.
- Holding registers are frozen from the IDLE→WRITE edge until the next capture. Changes on `req_data` or `req_addr` after capture have no effect.
- Units must drop `req_fleg` at the edge where they sample `req_ack` = 1. The arbiter samples `req_fleg` only in IDLE, so no double service occurs.
- `memFleg` is ignored outside WRITE.
- Requests arriving while the arbiter is busy wait; the flags are level-held.

## Timing
- Reset values: `memEN`, `memRW`, `req_ack`, `busy`, and `write_err` are 0. `memAddr`, `memWrite`, `grant_id`, `ptr`, and the holding registers are 0. State is IDLE.
- `RESET` asserted mid-operation:
  - Aborts immediately and asynchronously.
  - No ack is issued; the pending unit is re-served after reset if its flag is still high.
- Latency, with the flag first seen in IDLE at cycle 0:
  - `memEN` is high from cycle 1.
  - `memFleg` seen at cycle k gives the ack at cycle k+1.
  - The next capture can happen at cycle k+2.
  - The minimum service time is 3 cycles when `memFleg` returns in the first WRITE cycle.
- Timeout path: `write_err` rises in the first ACK cycle. The ack still occurs.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package `result_arb_pkg`:
  - State enum: IDLE, WRITE, ACK.
  - Constants BUS_W, ADDR_W, and the unit indices UNIT_MULT=0, UNIT_ADDSUB=1, UNIT_TRAN=2.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector and `ptr`.
  - Outputs: `winner` index and `any_req`.

## Test plan
- Mult only: `req_fleg`=001, addr 8'h10, data with every element 16'h0003, `memFleg` returned 1 cycle after `memEN` → `memAddr`=10, `memWrite` matches the data, `req_ack`=001 pulse, 4 cycles end to end.
- All three flags held, `ptr`=0 → service order 0, 1, 2, then 0 again if flag 0 is reasserted; exactly one ack per service.
- Flag 2 already pending; data on unit 1 changes during WRITE → the written data equals the value captured at grant.
- `memFleg` never asserted → `write_err`=1 after 64 WRITE cycles, ack still pulses, the next request is served normally.
- `RESET` pulsed during WRITE → `memEN` drops asynchronously, no ack, state IDLE, `ptr`=0, `write_err`=0.
